// File: rtl/down_counter_timer_if.sv
// Control/status bundle for down_counter_timer: start/load/tick/abort in, count and status out.
// Latency: none (wires only).
// Backpressure: none; the timer accepts its inputs every cycle.
interface down_counter_timer_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] start_value;
   logic             tick;
   logic             abort;
   logic [WIDTH-1:0] q;
   logic             busy;
   logic             done;

   modport master (
      output start, start_value, tick, abort,
      input  q, busy, done
   );

   modport slave (
      input  start, start_value, tick, abort,
      output q, busy, done
   );
endinterface

// File: rtl/down_counter_timer.sv
// Loadable down-counter/timer with one-cycle done pulse; DOWN_COUNTER_AUTO_RELOAD_EN selects periodic reload.
// Latency: q/busy one cycle after start; done N cycles after start for N ticks; all outputs registered.
// Backpressure: none; abort > start > tick are acted on every edge, tick ignored while idle.
module down_counter_timer #(
   parameter int WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  clear_n,
   down_counter_timer_if.slave   tmr
);

`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
   localparam bit AUTO_RELOAD = 1'b1;
`else
   localparam bit AUTO_RELOAD = 1'b0;
`endif

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t           state_r, state_n;
   logic [WIDTH-1:0] q_r, q_n;
   logic [WIDTH-1:0] reload_r, reload_n;
   logic             busy_r, busy_n;
   logic             done_r, done_n;

   logic             in_run_tick;
   logic             dec_en;
   logic [WIDTH-1:0] tgl;
   logic [WIDTH-1:0] q_dec;

   assign in_run_tick = (state_r == RUN) && tmr.tick && !tmr.abort && !tmr.start;
   assign dec_en      = in_run_tick && (q_r > ONE);

   // Toggle-enable decrement: a bit flips when every lower bit is already zero.
   for (genvar i = 0; i < WIDTH; i++) begin : g_tgl
      if (i == 0) begin : g_lsb
         assign tgl[i] = dec_en;
      end else begin : g_bit
         assign tgl[i] = dec_en && (q_r[i-1:0] == '0);
      end
   end

   assign q_dec = q_r ^ tgl;

   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         state_r  <= IDLE;
         q_r      <= '0;
         reload_r <= '0;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
      end else begin
         state_r  <= state_n;
         q_r      <= q_n;
         reload_r <= reload_n;
         busy_r   <= busy_n;
         done_r   <= done_n;
      end
   end

   always_comb begin
      state_n  = state_r;
      q_n      = q_r;
      reload_n = reload_r;
      busy_n   = busy_r;
      done_n   = 1'b0;

      if (tmr.abort) begin
         q_n     = '0;
         busy_n  = 1'b0;
         state_n = IDLE;
      end else if (tmr.start) begin
         reload_n = tmr.start_value;
         if (tmr.start_value != '0) begin
            q_n     = tmr.start_value;
            busy_n  = 1'b1;
            state_n = RUN;
         end else begin
            q_n     = '0;
            done_n  = 1'b1;
            busy_n  = 1'b0;
            state_n = IDLE;
         end
      end else if (in_run_tick) begin
         if (q_r == ONE) begin
            done_n = 1'b1;
            if (AUTO_RELOAD) begin
               q_n     = reload_r;
               busy_n  = 1'b1;
               state_n = RUN;
            end else begin
               q_n     = '0;
               busy_n  = 1'b0;
               state_n = IDLE;
            end
         end else if (dec_en) begin
            q_n = q_dec;
         end
      end
   end

   assign tmr.q    = q_r;
   assign tmr.busy = busy_r;
   assign tmr.done = done_r;

endmodule
